// File: rtl/iccm_uart_loader.sv
// UART boot loader for the ICCM: receives 8N1 bytes, packs them little-endian into
// words, writes consecutive ICCM addresses and holds the core in reset while loading.
module iccm_uart_loader #(
  parameter int          AddrWidth   = 12,
  parameter int          DataWidth   = 32,
  parameter int          ClkDivWidth = 16,
  parameter logic [63:0] EndWord     = 64'h0000_0000_0000_0FFF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rx_i,
  input  logic [ClkDivWidth-1:0] clks_per_bit_i,
  input  logic                   rearm_i,
  output logic                   we_o,
  output logic [AddrWidth-1:0]   addr_o,
  output logic [DataWidth-1:0]   wdata_o,
  output logic                   core_rst_no,
  output logic                   done_o,
  output logic                   err_o,
  output logic [AddrWidth:0]     word_cnt_o
);

  localparam int Lanes = DataWidth / 8;
  localparam int LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam int CntW  = AddrWidth + 1;
  localparam logic [LaneW-1:0]     LastLane = LaneW'(Lanes - 1);
  localparam logic [DataWidth-1:0] EndVal   = EndWord[DataWidth-1:0];

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_WAIT} bstate_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  logic                   rx_s1_q, rx_s2_q, rx_prev_q;
  bstate_e                bst_q;
  logic [ClkDivWidth-1:0] div_q, cnt_q, div_d;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;
  logic                   byte_vld_q, frame_err_q;

  state_e                 state_q;
  logic                   we_q, core_rst_nq, done_q, err_q;
  logic [AddrWidth-1:0]   addr_out_q, addr_q;
  logic [DataWidth-1:0]   wdata_q, word_q, word_d;
  logic [CntW-1:0]        wcnt_q;
  logic [LaneW-1:0]       lane_q;

  assign div_d = (clks_per_bit_i < ClkDivWidth'(2)) ? ClkDivWidth'(2) : clks_per_bit_i;

  always_comb begin
    word_d = word_q;
    for (int k = 0; k < Lanes; k++) begin
      if (lane_q == LaneW'(k)) word_d[8*k +: 8] = shift_q;
    end
  end

  // Bit engine: counters run in the synchronised domain; samples land mid-bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      bst_q       <= B_IDLE;
      div_q       <= ClkDivWidth'(2);
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= rx_i;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (bst_q)
        B_IDLE: if (!rx_s2_q && rx_prev_q) begin
          div_q <= div_d;
          cnt_q <= (div_d >> 1) - ClkDivWidth'(1);
          bst_q <= B_START;
        end
        B_START: begin
          if (cnt_q == '0) begin
            if (rx_s2_q) begin
              bst_q <= B_IDLE;
            end else begin
              cnt_q     <= div_q - ClkDivWidth'(1);
              bit_idx_q <= '0;
              bst_q     <= B_DATA;
            end
          end else begin
            cnt_q <= cnt_q - ClkDivWidth'(1);
          end
        end
        B_DATA: begin
          if (cnt_q == '0) begin
            shift_q   <= {rx_s2_q, shift_q[7:1]};
            cnt_q     <= div_q - ClkDivWidth'(1);
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) bst_q <= B_STOP;
          end else begin
            cnt_q <= cnt_q - ClkDivWidth'(1);
          end
        end
        B_STOP: begin
          if (cnt_q == '0) begin
            if (rx_s2_q) begin
              byte_vld_q <= 1'b1;
              bst_q      <= B_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              bst_q       <= B_WAIT;
            end
          end else begin
            cnt_q <= cnt_q - ClkDivWidth'(1);
          end
        end
        B_WAIT: if (rx_s2_q) bst_q <= B_IDLE;
        default: bst_q <= B_IDLE;
      endcase
    end
  end

  // Loader FSM: packs lanes, issues writes the cycle after a word completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_out_q  <= '0;
      wdata_q     <= '0;
      core_rst_nq <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      lane_q      <= '0;
      word_q      <= '0;
    end else begin
      we_q <= 1'b0;
      if (frame_err_q) err_q <= 1'b1;
      case (state_q)
        S_IDLE, S_LOAD: if (byte_vld_q) begin
          state_q     <= S_LOAD;
          core_rst_nq <= 1'b0;
          word_q      <= word_d;
          if (lane_q == LastLane) begin
            lane_q <= '0;
            if (word_d == EndVal) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              core_rst_nq <= 1'b1;
            end else begin
              we_q       <= 1'b1;
              addr_out_q <= addr_q;
              wdata_q    <= word_d;
              wcnt_q     <= wcnt_q + CntW'(1);
              if (addr_q == '1) begin
                err_q       <= 1'b1;
                state_q     <= S_DONE;
                done_q      <= 1'b1;
                core_rst_nq <= 1'b1;
              end else begin
                addr_q <= addr_q + AddrWidth'(1);
              end
            end
          end else begin
            lane_q <= lane_q + LaneW'(1);
          end
        end
        S_DONE: if (rearm_i) begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          lane_q  <= '0;
          addr_q  <= '0;
          wcnt_q  <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign we_o        = we_q;
  assign addr_o      = addr_out_q;
  assign wdata_o     = wdata_q;
  assign core_rst_no = core_rst_nq;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign word_cnt_o  = wcnt_q;

endmodule

// File: tb/tb_iccm_uart_loader.sv
// Bench for iccm_uart_loader: one full-size instance and one with a 2-bit address
// space; ICCM writes are checked against queues of expected writes.
module tb_iccm_uart_loader;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n, rx_a, rx_b, rearm;
  logic [15:0] cpb;

  logic        we_a, crn_a, done_a, err_a;
  logic [11:0] addr_a;
  logic [31:0] wd_a;
  logic [12:0] wc_a;

  logic        we_b, crn_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b;
  logic [2:0]  wc_b;

  int  n_cmp = 0;
  int  n_mis = 0;
  wr_t qa[$];
  wr_t qb[$];
  wr_t ea, eb;

  always #5 clk = ~clk;

  iccm_uart_loader dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .clks_per_bit_i(cpb), .rearm_i(rearm),
    .we_o(we_a), .addr_o(addr_a), .wdata_o(wd_a), .core_rst_no(crn_a),
    .done_o(done_a), .err_o(err_a), .word_cnt_o(wc_a)
  );

  iccm_uart_loader #(.AddrWidth(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .clks_per_bit_i(cpb), .rearm_i(rearm),
    .we_o(we_b), .addr_o(addr_b), .wdata_o(wd_b), .core_rst_no(crn_b),
    .done_o(done_b), .err_o(err_b), .word_cnt_o(wc_b)
  );

  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_mis++;
        $display("FAIL wr_a_unexpected: got addr=%0h data=%h, expected no write", addr_a, wd_a);
      end else begin
        ea = qa.pop_front();
        if (addr_a !== ea.addr || wd_a !== ea.data) begin
          n_mis++;
          $display("FAIL wr_a: got addr=%0h data=%h, expected addr=%0h data=%h",
                   addr_a, wd_a, ea.addr, ea.data);
        end
      end
    end
    if (we_b === 1'b1) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_mis++;
        $display("FAIL wr_b_unexpected: got addr=%0h data=%h, expected no write", addr_b, wd_b);
      end else begin
        eb = qb.pop_front();
        if (addr_b !== eb.addr[1:0] || wd_b !== eb.data) begin
          n_mis++;
          $display("FAIL wr_b: got addr=%0h data=%h, expected addr=%0h data=%h",
                   addr_b, wd_b, eb.addr[1:0], eb.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit stop_ok);
    int d;
    d = (cpb < 16'd2) ? 2 : int'(cpb);
    set_rx(sel, 1'b0);
    tick(d);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      tick(d);
    end
    set_rx(sel, stop_ok);
    tick(d);
    set_rx(sel, 1'b1);
    tick(4);
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(sel, w[8*i +: 8], 1'b1);
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    tick(2);
  endtask

  task automatic wait_done_a(input string name);
    int k;
    k = 0;
    while (done_a !== 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (done_a !== 1'b1) begin
      n_mis++;
      $display("FAIL %s_done_timeout: got done_o=%b, expected 1", name, done_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rearm = 1'b0; cpb = 16'd87;
    tick(3);
    n_cmp += 7;
    if (we_a !== 1'b0)    begin n_mis++; $display("FAIL rst_we: got %b, expected 0", we_a); end
    if (addr_a !== '0)    begin n_mis++; $display("FAIL rst_addr: got %h, expected 0", addr_a); end
    if (wd_a !== '0)      begin n_mis++; $display("FAIL rst_wdata: got %h, expected 0", wd_a); end
    if (crn_a !== 1'b1)   begin n_mis++; $display("FAIL rst_core_rst_n: got %b, expected 1", crn_a); end
    if (done_a !== 1'b0)  begin n_mis++; $display("FAIL rst_done: got %b, expected 0", done_a); end
    if (err_a !== 1'b0)   begin n_mis++; $display("FAIL rst_err: got %b, expected 0", err_a); end
    if (wc_a !== '0)      begin n_mis++; $display("FAIL rst_word_cnt: got %0d, expected 0", wc_a); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_glitch();
    cpb = 16'd87;
    rx_a = 1'b0;
    tick(1);
    rx_a = 1'b1;
    tick(200);
    n_cmp += 2;
    if (crn_a !== 1'b1) begin n_mis++; $display("FAIL glitch_core_rst_n: got %b, expected 1", crn_a); end
    if (err_a !== 1'b0) begin n_mis++; $display("FAIL glitch_err: got %b, expected 0", err_a); end
  endtask

  task automatic test_image();
    logic [7:0] img [12];
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF, 8'h0F, 8'h00, 8'h00};
    cpb = 16'd87;
    qa.push_back('{addr: 12'd0, data: 32'h1234_5678});
    qa.push_back('{addr: 12'd1, data: 32'hDEAD_BEEF});
    for (int i = 0; i < 12; i++) begin
      send_byte(1'b0, img[i], 1'b1);
      if (i == 0 || i == 10) begin
        tick(3);
        n_cmp++;
        if (crn_a !== 1'b0) begin n_mis++; $display("FAIL image_core_held_%0d: got %b, expected 0", i, crn_a); end
      end
    end
    wait_done_a("image");
    n_cmp += 4;
    if (crn_a !== 1'b1)    begin n_mis++; $display("FAIL image_core_rst_n: got %b, expected 1", crn_a); end
    if (wc_a !== 13'd2)    begin n_mis++; $display("FAIL image_word_cnt: got %0d, expected 2", wc_a); end
    if (err_a !== 1'b0)    begin n_mis++; $display("FAIL image_err: got %b, expected 0", err_a); end
    if (qa.size() != 0)    begin n_mis++; $display("FAIL image_pending: got %0d writes missing, expected 0", qa.size()); end
    send_word(1'b0, 32'h5555_AAAA);
    tick(5);
    pulse_rearm();
    n_cmp += 4;
    if (done_a !== 1'b0)   begin n_mis++; $display("FAIL rearm_done: got %b, expected 0", done_a); end
    if (err_a !== 1'b0)    begin n_mis++; $display("FAIL rearm_err: got %b, expected 0", err_a); end
    if (wc_a !== '0)       begin n_mis++; $display("FAIL rearm_word_cnt: got %0d, expected 0", wc_a); end
    if (crn_a !== 1'b1)    begin n_mis++; $display("FAIL rearm_core_rst_n: got %b, expected 1", crn_a); end
  endtask

  task automatic test_framing();
    cpb = 16'd16;
    qa.push_back('{addr: 12'd0, data: 32'h4433_2211});
    send_byte(1'b0, 8'h11, 1'b1);
    send_byte(1'b0, 8'h99, 1'b0);
    tick(3);
    n_cmp++;
    if (err_a !== 1'b1) begin n_mis++; $display("FAIL framing_err: got %b, expected 1", err_a); end
    send_byte(1'b0, 8'h22, 1'b1);
    send_byte(1'b0, 8'h33, 1'b1);
    send_byte(1'b0, 8'h44, 1'b1);
    send_word(1'b0, 32'h0000_0FFF);
    wait_done_a("framing");
    n_cmp += 3;
    if (wc_a !== 13'd1)  begin n_mis++; $display("FAIL framing_word_cnt: got %0d, expected 1", wc_a); end
    if (err_a !== 1'b1)  begin n_mis++; $display("FAIL framing_err_sticky: got %b, expected 1", err_a); end
    if (qa.size() != 0)  begin n_mis++; $display("FAIL framing_pending: got %0d writes missing, expected 0", qa.size()); end
    pulse_rearm();
    n_cmp++;
    if (err_a !== 1'b0)  begin n_mis++; $display("FAIL framing_rearm_err: got %b, expected 0", err_a); end
  endtask

  task automatic test_marker_first();
    cpb = 16'd10;
    send_word(1'b0, 32'h0000_0FFF);
    wait_done_a("marker");
    n_cmp += 2;
    if (wc_a !== '0)    begin n_mis++; $display("FAIL marker_word_cnt: got %0d, expected 0", wc_a); end
    if (crn_a !== 1'b1) begin n_mis++; $display("FAIL marker_core_rst_n: got %b, expected 1", crn_a); end
    pulse_rearm();
    n_cmp += 2;
    if (done_a !== 1'b0) begin n_mis++; $display("FAIL marker_rearm_done: got %b, expected 0", done_a); end
    if (err_a !== 1'b0)  begin n_mis++; $display("FAIL marker_rearm_err: got %b, expected 0", err_a); end
  endtask

  task automatic test_reset_midload();
    cpb = 16'd10;
    send_byte(1'b0, 8'hA1, 1'b1);
    send_byte(1'b0, 8'hA2, 1'b1);
    tick(3);
    n_cmp++;
    if (crn_a !== 1'b0) begin n_mis++; $display("FAIL midload_core_held: got %b, expected 0", crn_a); end
    rst_n = 1'b0;
    tick(2);
    n_cmp++;
    if (crn_a !== 1'b1) begin n_mis++; $display("FAIL midload_rst_core_rst_n: got %b, expected 1", crn_a); end
    rst_n = 1'b1;
    tick(3);
    qa.push_back('{addr: 12'd0, data: 32'hCAFE_F00D});
    send_word(1'b0, 32'hCAFE_F00D);
    send_word(1'b0, 32'h0000_0FFF);
    wait_done_a("midload");
    n_cmp += 2;
    if (wc_a !== 13'd1) begin n_mis++; $display("FAIL midload_word_cnt: got %0d, expected 1", wc_a); end
    if (qa.size() != 0) begin n_mis++; $display("FAIL midload_pending: got %0d writes missing, expected 0", qa.size()); end
    pulse_rearm();
  endtask

  task automatic test_min_divisor();
    cpb = 16'd0;
    qa.push_back('{addr: 12'd0, data: 32'h0BAD_F1E5});
    qa.push_back('{addr: 12'd1, data: 32'h8000_0001});
    send_word(1'b0, 32'h0BAD_F1E5);
    send_word(1'b0, 32'h8000_0001);
    send_word(1'b0, 32'h0000_0FFF);
    wait_done_a("min_div");
    n_cmp += 3;
    if (wc_a !== 13'd2) begin n_mis++; $display("FAIL min_div_word_cnt: got %0d, expected 2", wc_a); end
    if (err_a !== 1'b0) begin n_mis++; $display("FAIL min_div_err: got %b, expected 0", err_a); end
    if (qa.size() != 0) begin n_mis++; $display("FAIL min_div_pending: got %0d writes missing, expected 0", qa.size()); end
    pulse_rearm();
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    int k;
    cpb = 16'd8;
    for (int i = 0; i < 5; i++) begin
      w = 32'h1000_0000 + 32'(i * 32'h0101_0101);
      if (i < 4) qb.push_back('{addr: 12'(i), data: w});
      send_word(1'b1, w);
    end
    k = 0;
    while (done_b !== 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
    n_cmp += 5;
    if (done_b !== 1'b1)  begin n_mis++; $display("FAIL ovf_done: got %b, expected 1", done_b); end
    if (err_b !== 1'b1)   begin n_mis++; $display("FAIL ovf_err: got %b, expected 1", err_b); end
    if (wc_b !== 3'd4)    begin n_mis++; $display("FAIL ovf_word_cnt: got %0d, expected 4", wc_b); end
    if (crn_b !== 1'b1)   begin n_mis++; $display("FAIL ovf_core_rst_n: got %b, expected 1", crn_b); end
    if (qb.size() != 0)   begin n_mis++; $display("FAIL ovf_pending: got %0d writes missing, expected 0", qb.size()); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_image();
    test_framing();
    test_marker_first();
    test_reset_midload();
    test_min_divisor();
    test_overflow();
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
